// File: rtl/svga_text_pixel_pipe.sv
// rtl/svga_text_pixel_pipe.sv - text/SG4 pixel stage: VRAM/font fetch, dot serialiser, aligned blank/border
module svga_text_pixel_pipe #(
    parameter int VRAM_AW = 9,
    parameter int FONT_AW = 10,
    parameter int FG0     = 0,
    parameter int BG0     = 9,
    parameter int FG1     = 7,
    parameter int BG1     = 10,
    parameter int BLACK   = 8
) (
    input  logic               pixel_clock,
    input  logic               reset,
    input  logic               blank,
    input  logic               show_border,
    input  logic [3:0]         subchar_pixel,
    input  logic [4:0]         subchar_line,
    input  logic [6:0]         char_column,
    input  logic [6:0]         char_line,
    input  logic               css,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [7:0]         vram_data,
    output logic [FONT_AW-1:0] font_addr,
    input  logic [7:0]         font_data,
    output logic [3:0]         color_idx,
    output logic               de
);

    localparam logic [3:0] FG0_C   = 4'(FG0);
    localparam logic [3:0] BG0_C   = 4'(BG0);
    localparam logic [3:0] FG1_C   = 4'(FG1);
    localparam logic [3:0] BG1_C   = 4'(BG1);
    localparam logic [3:0] BLACK_C = 4'(BLACK);

    typedef enum logic [2:0] {IDLE, VADDR, VWAIT, FADDR, FWAIT, READY} fetch_state_t;

    fetch_state_t state, state_next;

    logic [3:0]  prev_pixel;
    logic        trig, load;
    logic        addr_en, code_en, build_en;
    logic [3:0]  row;
    logic [7:0]  code;
    logic [7:0]  next_pat;
    logic [3:0]  next_fg, next_bg;
    logic        ready;
    logic [7:0]  pat;
    logic [3:0]  fg, bg;
    logic [3:0]  out_phase;
    logic        active;
    logic [16:0] blank_dl, border_dl;
    logic [7:0]  build_pat;
    logic [3:0]  build_fg, build_bg;
    logic [3:0]  text_fg, text_bg;
    logic        sg_left, sg_right, dot;
    logic        unused_bits;

    assign unused_bits = ^{char_column[6:5], char_line[6:4], subchar_line[0]};

    assign trig = (subchar_pixel == 4'd1) && (prev_pixel == 4'd0);
    assign load = (prev_pixel == 4'd15) && (subchar_pixel != 4'd15);

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr_en    = 1'b0;
        code_en    = 1'b0;
        build_en   = 1'b0;
        if (trig) begin
            state_next = VADDR;
            addr_en    = 1'b1;
        end else begin
            case (state)
                VADDR:   state_next = VWAIT;
                VWAIT: begin
                    state_next = FADDR;
                    code_en    = 1'b1;
                end
                FADDR:   state_next = FWAIT;
                FWAIT: begin
                    state_next = READY;
                    build_en   = 1'b1;
                end
                READY:   if (load) state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    assign text_fg = css ? FG1_C : FG0_C;
    assign text_bg = css ? BG1_C : BG0_C;

    // SG4 quadrants: rows 0-5 use TL/TR, rows 6-11 use BL/BR
    assign sg_left  = (row < 4'd6) ? code[3] : code[1];
    assign sg_right = (row < 4'd6) ? code[2] : code[0];

    always_comb begin
        build_pat = font_data;
        build_fg  = text_fg;
        build_bg  = text_bg;
        if (code[7]) begin
            build_pat = {{4{sg_left}}, {4{sg_right}}};
            build_fg  = {1'b0, code[6:4]};
            build_bg  = BLACK_C;
        end else if (code[6]) begin
            build_fg  = text_bg;
            build_bg  = text_fg;
        end
    end

    assign dot = pat[3'd7 - out_phase[3:1]];

    always_ff @(posedge pixel_clock or posedge reset) begin
        if (reset) begin
            prev_pixel <= 4'd0;
            vram_addr  <= '0;
            font_addr  <= '0;
            row        <= 4'd0;
            code       <= 8'd0;
            next_pat   <= 8'd0;
            next_fg    <= 4'd0;
            next_bg    <= 4'd0;
            ready      <= 1'b0;
            pat        <= 8'd0;
            fg         <= 4'd0;
            bg         <= 4'd0;
            out_phase  <= 4'd0;
            active     <= 1'b0;
            blank_dl   <= '1;
            border_dl  <= '1;
            color_idx  <= BLACK_C;
            de         <= 1'b0;
        end else begin
            prev_pixel <= subchar_pixel;
            blank_dl   <= {blank_dl[15:0], blank};
            border_dl  <= {border_dl[15:0], show_border};

            if (addr_en) begin
                vram_addr <= VRAM_AW'({char_line[3:0], char_column[4:0]});
                row       <= subchar_line[4:1];
            end
            if (code_en) begin
                code      <= vram_data;
                font_addr <= FONT_AW'({vram_data[5:0], row});
            end
            if (build_en) begin
                next_pat <= build_pat;
                next_fg  <= build_fg;
                next_bg  <= build_bg;
                ready    <= 1'b1;
            end

            // A load without a completed fetch shows a blank background cell
            if (load) begin
                pat       <= ready ? next_pat : 8'd0;
                fg        <= ready ? next_fg : text_bg;
                bg        <= ready ? next_bg : text_bg;
                ready     <= 1'b0;
                out_phase <= 4'd0;
                active    <= 1'b1;
            end else if (active) begin
                out_phase <= out_phase + 4'd1;
                if (out_phase == 4'd15) active <= 1'b0;
            end

            if (blank_dl[16]) begin
                color_idx <= BLACK_C;
                de        <= 1'b0;
            end else if (border_dl[16]) begin
                color_idx <= BLACK_C;
                de        <= 1'b1;
            end else begin
                color_idx <= active ? (dot ? fg : bg) : BLACK_C;
                de        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_svga_text_pixel_pipe.sv
// tb/tb_svga_text_pixel_pipe.sv - directed self-checking bench for svga_text_pixel_pipe
module tb_svga_text_pixel_pipe;

    logic       pixel_clock = 1'b0;
    logic       reset;
    logic       blank;
    logic       show_border;
    logic [3:0] subchar_pixel;
    logic [4:0] subchar_line;
    logic [6:0] char_column;
    logic [6:0] char_line;
    logic       css;
    logic [8:0] vram_addr;
    logic [7:0] vram_data;
    logic [9:0] font_addr;
    logic [7:0] font_data;
    logic [3:0] color_idx;
    logic       de;

    logic [7:0] vram [512];
    logic [7:0] font_rom [1024];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int starts [10];
    int r0;

    logic [3:0] hist_color [512];
    logic       hist_de    [512];
    logic [8:0] hist_va    [512];
    logic [9:0] hist_fa    [512];

    svga_text_pixel_pipe dut (
        .pixel_clock   (pixel_clock),
        .reset         (reset),
        .blank         (blank),
        .show_border   (show_border),
        .subchar_pixel (subchar_pixel),
        .subchar_line  (subchar_line),
        .char_column   (char_column),
        .char_line     (char_line),
        .css           (css),
        .vram_addr     (vram_addr),
        .vram_data     (vram_data),
        .font_addr     (font_addr),
        .font_data     (font_data),
        .color_idx     (color_idx),
        .de            (de)
    );

    always #5 pixel_clock = ~pixel_clock;

    always @(posedge pixel_clock) begin
        vram_data <= vram[vram_addr];
        font_data <= font_rom[font_addr];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge pixel_clock);
        #1;
        hist_color[cyc] = color_idx;
        hist_de[cyc]    = de;
        hist_va[cyc]    = vram_addr;
        hist_fa[cyc]    = font_addr;
        cyc++;
    endtask

    task automatic run_char(input int col, input int line, input int subline, input logic css_v,
                            input logic skip_trig, input logic [15:0] blank_mask,
                            input logic [15:0] border_mask);
        for (int p = 0; p < 16; p++) begin
            subchar_pixel = (skip_trig && p == 1) ? 4'd2 : 4'(p);
            subchar_line  = 5'(subline);
            char_column   = 7'(col);
            char_line     = 7'(line);
            css           = css_v;
            blank         = blank_mask[p];
            show_border   = border_mask[p];
            step();
        end
    endtask

    // colours are nibbles, first dot in the top nibble; de_bits bit k = dot k
    task automatic check_window(input string tag, input int start, input logic [63:0] colors,
                                input logic [15:0] de_bits);
        for (int k = 0; k < 16; k++) begin
            check($sformatf("%s_color[%0d]", tag, k), 16'(hist_color[start + 17 + k]),
                  16'(colors[63 - 4*k -: 4]));
            check($sformatf("%s_de[%0d]", tag, k), 16'(hist_de[start + 17 + k]), 16'(de_bits[k]));
        end
    endtask

    initial begin
        reset         = 1'b1;
        blank         = 1'b1;
        show_border   = 1'b0;
        css           = 1'b0;
        subchar_pixel = 4'd0;
        subchar_line  = 5'd0;
        char_column   = 7'd0;
        char_line     = 7'd0;
        for (int i = 0; i < 512; i++) vram[i] = 8'h00;
        for (int i = 0; i < 1024; i++) font_rom[i] = 8'h00;
        vram[9'h0BF]      = 8'h01;
        font_rom[10'h013] = 8'hA5;
        font_rom[10'h010] = 8'hA5;
        vram[1] = 8'h01;
        vram[2] = 8'h41;
        vram[3] = 8'hB9;
        vram[4] = 8'hB9;
        vram[6] = 8'h01;
        vram[7] = 8'h01;

        repeat (3) @(posedge pixel_clock);
        #1;
        check("reset_color", 16'(color_idx), 16'd8);
        check("reset_de", 16'(de), 16'd0);
        check("reset_vram_addr", 16'(vram_addr), 16'h000);
        check("reset_font_addr", 16'(font_addr), 16'h000);

        reset = 1'b0;
        blank = 1'b0;
        repeat (4) step();

        starts[0] = cyc; run_char(31, 5, 6, 1'b0, 1'b0, 16'h0000, 16'h0000);
        starts[1] = cyc; run_char(1, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        starts[2] = cyc; run_char(2, 0, 1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        starts[3] = cyc; run_char(3, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        starts[4] = cyc; run_char(4, 0, 12, 1'b0, 1'b0, 16'h0000, 16'h0000);
        starts[5] = cyc; run_char(5, 0, 0, 1'b0, 1'b1, 16'h0000, 16'h0000);
        starts[6] = cyc; run_char(6, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        starts[7] = cyc; run_char(7, 0, 0, 1'b0, 1'b0, 16'h0078, 16'h1C00);
        starts[8] = cyc; run_char(8, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        starts[9] = cyc; run_char(9, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        check("vram_addr_c0", 16'(hist_va[starts[0] + 1]), 16'h0BF);
        check("font_addr_c0", 16'(hist_fa[starts[0] + 3]), 16'h013);
        check("vram_addr_c1", 16'(hist_va[starts[1] + 1]), 16'h001);
        check("font_addr_c3", 16'(hist_fa[starts[3] + 3]), 16'h390);

        check_window("text_row3",   starts[0], 64'h0099_0099_9900_9900, 16'hFFFF);
        check_window("text_css0",   starts[1], 64'h0099_0099_9900_9900, 16'hFFFF);
        check_window("inverse_css1", starts[2], 64'hAA77_AA77_77AA_77AA, 16'hFFFF);
        check_window("sg4_row0",    starts[3], 64'h3333_3333_8888_8888, 16'hFFFF);
        check_window("sg4_row6",    starts[4], 64'h8888_8888_3333_3333, 16'hFFFF);
        check_window("missed_fetch", starts[5], 64'h9999_9999_9999_9999, 16'hFFFF);
        check_window("recovered",   starts[6], 64'h0099_0099_9900_9900, 16'hFFFF);
        check_window("blank_border", starts[7], 64'h0098_8889_9988_8900, 16'hFF87);

        check("pre_reset_color", 16'(color_idx), 16'd9);
        check("pre_reset_de", 16'(de), 16'd1);
        check("pre_reset_vram_addr", 16'(vram_addr), 16'h009);
        subchar_pixel = 4'd5;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_color", 16'(color_idx), 16'd8);
        check("midrst_de", 16'(de), 16'd0);
        check("midrst_vram_addr", 16'(vram_addr), 16'h000);
        check("midrst_font_addr", 16'(font_addr), 16'h000);
        check("midrst_fsm_idle", 16'(dut.state), 16'(dut.IDLE));

        repeat (2) @(posedge pixel_clock);
        #1;
        reset         = 1'b0;
        subchar_pixel = 4'd0;
        blank         = 1'b0;
        show_border   = 1'b0;
        step();
        step();
        check("post_rst_de", 16'(hist_de[cyc - 1]), 16'd0);
        check("post_rst_color", 16'(hist_color[cyc - 1]), 16'd8);

        r0 = cyc;
        run_char(1, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        run_char(8, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        run_char(9, 0, 0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        check_window("after_reset", r0, 64'h0099_0099_9900_9900, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
